ex_mem_stage_reg: RTL and testbench

Parametrised EX/MEM pipeline stage register for the MIPS pipeline.
- Replaces the fixed-width EX/MEM latch with a valid/ready handshake so the stage can stall on backpressure, plus flush-to-bubble.
- Exception-entry injection writes the return PC to the exception register. A request that arrives while stalled is held in a pending state until it can be injected.
- Sits between the ALU stage and the data-memory stage.

---
 rtl/ex_mem_stage_reg.sv | 154 +++++++++++++++
 tb/tb_ex_mem_stage_reg.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/ex_mem_stage_reg.sv
// EX/MEM pipeline stage register with valid/ready backpressure, flush-to-bubble
// and exception-entry injection. Define EXMEM_STATS_EN to enable the statistics counters.
module ex_mem_stage_reg #(
  parameter int                 DATA_W   = 32,
  parameter int                 RADDR_W  = 5,
  parameter logic [DATA_W-1:0]  RESET_PC = 32'h80000004,
  parameter int                 EXC_REG  = 26,
  parameter int                 PCSRC_W  = 3
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               in_valid,
  output logic               in_ready,
  output logic               out_valid,
  input  logic               out_ready,
  input  logic               flush,
  input  logic               exc_req,
  input  logic [PCSRC_W-1:0] pcsrc_id,
  input  logic               regwr_in,
  input  logic               memwr_in,
  input  logic               memrd_in,
  input  logic [1:0]         memtoreg_in,
  input  logic [DATA_W-1:0]  newpc_in,
  input  logic [DATA_W-1:0]  alu_in,
  input  logic [DATA_W-1:0]  stdata_in,
  input  logic [DATA_W-1:0]  pc4_in,
  input  logic [RADDR_W-1:0] rd_in,
  input  logic               flushed_ex,
  input  logic               flushed_id,
  input  logic [DATA_W-1:0]  pc4_id,
  input  logic [DATA_W-1:0]  pc4_if,
  output logic [PCSRC_W-1:0] pcsrc_out,
  output logic               regwr_out,
  output logic               memwr_out,
  output logic               memrd_out,
  output logic [1:0]         memtoreg_out,
  output logic [DATA_W-1:0]  newpc_out,
  output logic [DATA_W-1:0]  alu_out,
  output logic [DATA_W-1:0]  stdata_out,
  output logic [DATA_W-1:0]  pc4_out,
  output logic [RADDR_W-1:0] rd_out,
  output logic               exc_pending,
  output logic [15:0]        stall_cnt,
  output logic [15:0]        bubble_cnt,
  output logic [15:0]        exc_cnt
);

  typedef enum logic {RUN, EXC_PEND} state_t;

  state_t            state, nextState;
  logic [DATA_W-1:0] epc, epcHeld;
  logic              inject, loadBubble;

  assign in_ready    = !out_valid || out_ready;
  assign exc_pending = (state == EXC_PEND);
  assign inject      = in_ready && ((state == EXC_PEND) || exc_req);
  assign loadBubble  = in_ready && !inject && (flush || !in_valid);

  // Return PC: first slot (EX, then ID) holding a live, non-kernel instruction, else fetch.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    epc = pc4_if;
    if (!(pc4_in[DATA_W-1] || flushed_ex))
      epc = pc4_in;
    else if (!(pc4_id[DATA_W-1] || flushed_id))
      epc = pc4_id;
  end

  always_comb begin
    nextState = state;
    if (in_ready)
      nextState = RUN;
    else if (state == RUN && exc_req)
      nextState = EXC_PEND;
  end

  always_ff @(posedge clk or negedge reset) begin
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    if (!reset) begin
      state   <= RUN;
      epcHeld <= '0;
    end else begin
      state <= nextState;
      if (!in_ready && state == RUN && exc_req)
        epcHeld <= epc;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      out_valid    <= 1'b0;
      pcsrc_out    <= '0;
      regwr_out    <= 1'b0;
      memwr_out    <= 1'b0;
      memrd_out    <= 1'b0;
      memtoreg_out <= 2'd0;
      newpc_out    <= RESET_PC;
      alu_out      <= '0;
      stdata_out   <= '0;
      pc4_out      <= RESET_PC;
      rd_out       <= '0;
    end else if (in_ready) begin
      pcsrc_out  <= pcsrc_id;
      newpc_out  <= newpc_in;
      alu_out    <= alu_in;
      stdata_out <= stdata_in;
      if (inject) begin
        out_valid    <= 1'b1;
        regwr_out    <= 1'b1;
        memwr_out    <= 1'b0;
        memrd_out    <= 1'b0;
        memtoreg_out <= 2'd2;
        rd_out       <= RADDR_W'(EXC_REG);
        pc4_out      <= (state == EXC_PEND) ? epcHeld : epc;
      end else begin
        out_valid    <= !loadBubble;
        regwr_out    <= regwr_in && !loadBubble;
        memwr_out    <= memwr_in && !loadBubble;
        memrd_out    <= memrd_in && !loadBubble;
        memtoreg_out <= memtoreg_in;
        rd_out       <= rd_in;
        pc4_out      <= pc4_in;
      end
    end
  end

`ifdef EXMEM_STATS_EN
  logic [15:0] stallCnt, bubbleCnt, excCnt;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      stallCnt  <= '0;
      bubbleCnt <= '0;
      excCnt    <= '0;
    end else begin
      if (out_valid && !out_ready && stallCnt != 16'hFFFF)
        stallCnt <= stallCnt + 16'd1;
      if (loadBubble && bubbleCnt != 16'hFFFF)
        bubbleCnt <= bubbleCnt + 16'd1;
      if (inject && excCnt != 16'hFFFF)
        excCnt <= excCnt + 16'd1;
    end
  end

  assign stall_cnt  = stallCnt;
  assign bubble_cnt = bubbleCnt;
  assign exc_cnt    = excCnt;
`else
  assign stall_cnt  = 16'd0;
  assign bubble_cnt = 16'd0;
  assign exc_cnt    = 16'd0;
`endif

endmodule

// File: tb/tb_ex_mem_stage_reg.sv
// Scoreboard bench for ex_mem_stage_reg: expected entries are queued when driven
// and compared when the MEM side consumes them.
module tb_ex_mem_stage_reg;

  localparam int DW = 32;
  localparam int RW = 5;
  localparam int PW = 3;
  localparam logic [31:0] RST_PC = 32'h80000004;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          in_valid, in_ready, out_valid, out_ready, flush, exc_req;
  logic [PW-1:0] pcsrc_id, pcsrc_out;
  logic          regwr_in, memwr_in, memrd_in, regwr_out, memwr_out, memrd_out;
  logic [1:0]    memtoreg_in, memtoreg_out;
  logic [DW-1:0] newpc_in, alu_in, stdata_in, pc4_in, pc4_id, pc4_if;
  logic [DW-1:0] newpc_out, alu_out, stdata_out, pc4_out;
  logic [RW-1:0] rd_in, rd_out;
  logic          flushed_ex, flushed_id, exc_pending;
  logic [15:0]   stall_cnt, bubble_cnt, exc_cnt;

  always #5 clk = ~clk;

  ex_mem_stage_reg dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .out_valid(out_valid), .out_ready(out_ready), .flush(flush), .exc_req(exc_req),
    .pcsrc_id(pcsrc_id), .regwr_in(regwr_in), .memwr_in(memwr_in), .memrd_in(memrd_in),
    .memtoreg_in(memtoreg_in), .newpc_in(newpc_in), .alu_in(alu_in), .stdata_in(stdata_in),
    .pc4_in(pc4_in), .rd_in(rd_in), .flushed_ex(flushed_ex), .flushed_id(flushed_id),
    .pc4_id(pc4_id), .pc4_if(pc4_if), .pcsrc_out(pcsrc_out), .regwr_out(regwr_out),
    .memwr_out(memwr_out), .memrd_out(memrd_out), .memtoreg_out(memtoreg_out),
    .newpc_out(newpc_out), .alu_out(alu_out), .stdata_out(stdata_out), .pc4_out(pc4_out),
    .rd_out(rd_out), .exc_pending(exc_pending), .stall_cnt(stall_cnt),
    .bubble_cnt(bubble_cnt), .exc_cnt(exc_cnt)
  );

  typedef struct {
    logic [31:0] alu;
    logic [31:0] pc4;
    logic [4:0]  rd;
    logic        regwr;
    logic        memwr;
    logic [1:0]  memtoreg;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;

  task automatic push_exp(input logic [31:0] alu, input logic [31:0] pc4, input logic [4:0] rd,
                          input logic regwr, input logic memwr, input logic [1:0] mtr);
    exp_t e;
    e.alu = alu; e.pc4 = pc4; e.rd = rd; e.regwr = regwr; e.memwr = memwr; e.memtoreg = mtr;
    sb.push_back(e);
  endtask

  // Consume the presented entry (if the MEM side takes it this edge), then advance one clock.
  task automatic cycle();
    exp_t e;
    if (out_valid && out_ready) begin
      checks++;
      if (sb.size() == 0) begin
        errors++;
        $display("FAIL sb_unexpected: got entry alu_out=%h pc4_out=%h, expected none", alu_out, pc4_out);
      end else begin
        e = sb.pop_front();
        if ({alu_out, pc4_out, rd_out, regwr_out, memwr_out, memtoreg_out} !==
            {e.alu, e.pc4, e.rd, e.regwr, e.memwr, e.memtoreg}) begin
          errors++;
          $display("FAIL sb_entry: got alu=%h pc4=%h rd=%0d regwr=%b memwr=%b mtr=%0d, expected alu=%h pc4=%h rd=%0d regwr=%b memwr=%b mtr=%0d",
                   alu_out, pc4_out, rd_out, regwr_out, memwr_out, memtoreg_out,
                   e.alu, e.pc4, e.rd, e.regwr, e.memwr, e.memtoreg);
        end
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic set_idle();
    in_valid = 0; flush = 0; exc_req = 0; out_ready = 1; pcsrc_id = '0;
    regwr_in = 0; memwr_in = 0; memrd_in = 0; memtoreg_in = 2'd0;
    newpc_in = '0; alu_in = '0; stdata_in = '0; pc4_in = '0; rd_in = '0;
    flushed_ex = 0; flushed_id = 0; pc4_id = '0; pc4_if = '0;
  endtask

  task automatic drive_valid(input logic [31:0] alu, input logic [31:0] pc4);
    in_valid = 1; alu_in = alu; pc4_in = pc4; regwr_in = 1; memwr_in = 0;
    rd_in = 5'd3; memtoreg_in = 2'd1; newpc_in = alu + 32'h100;
  endtask

  task automatic apply_reset();
    set_idle();
    reset = 0;
    sb.delete();
    @(posedge clk);
    #1;
    reset = 1;
  endtask

  task automatic test_reset();
    set_idle();
    reset = 0;
    #12;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rst_out_valid: got %b, expected 0", out_valid); end
    checks++; if (pc4_out !== RST_PC) begin errors++; $display("FAIL rst_pc4: got %h, expected %h", pc4_out, RST_PC); end
    checks++; if (newpc_out !== RST_PC) begin errors++; $display("FAIL rst_newpc: got %h, expected %h", newpc_out, RST_PC); end
    checks++; if ({regwr_out, memwr_out, memrd_out, memtoreg_out, rd_out, alu_out} !== 42'd0) begin
      errors++; $display("FAIL rst_fields: got regwr=%b memwr=%b memrd=%b mtr=%0d rd=%0d alu=%h, expected all 0",
                         regwr_out, memwr_out, memrd_out, memtoreg_out, rd_out, alu_out); end
    checks++; if (exc_pending !== 1'b0) begin errors++; $display("FAIL rst_exc_pending: got %b, expected 0", exc_pending); end
    @(posedge clk);
    #1;
    reset = 1;
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL rst_in_ready: got %b, expected 1", in_ready); end
  endtask

  task automatic test_stream_backpressure();
    set_idle();
    drive_valid(32'd1, 32'h00400004); push_exp(32'd1, 32'h00400004, 5'd3, 1, 0, 2'd1);
    cycle();
    drive_valid(32'd2, 32'h00400008); out_ready = 0;
    #1;
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL bp_in_ready: got %b, expected 0", in_ready); end
    for (int i = 0; i < 2; i++) begin
      cycle();
      checks++; if (alu_out !== 32'd1 || out_valid !== 1'b1) begin
        errors++; $display("FAIL bp_hold%0d: got alu_out=%h out_valid=%b, expected 1/1", i, alu_out, out_valid); end
    end
    out_ready = 1; push_exp(32'd2, 32'h00400008, 5'd3, 1, 0, 2'd1);
    cycle();
    drive_valid(32'd3, 32'h0040000c); push_exp(32'd3, 32'h0040000c, 5'd3, 1, 0, 2'd1);
    cycle();
    set_idle();
    cycle();
    checks++; if (sb.size() != 0 || out_valid !== 1'b0) begin
      errors++; $display("FAIL bp_drain: got %0d queued, out_valid=%b, expected 0/0", sb.size(), out_valid); end
  endtask

  task automatic test_flush();
    set_idle();
    drive_valid(32'd55, 32'h00400100); memwr_in = 1; flush = 1;
    cycle();
    checks++; if ({out_valid, regwr_out, memwr_out} !== 3'b000) begin
      errors++; $display("FAIL flush_ctrl: got valid=%b regwr=%b memwr=%b, expected 000", out_valid, regwr_out, memwr_out); end
    checks++; if (alu_out !== 32'd55) begin errors++; $display("FAIL flush_alu: got %h, expected %h", alu_out, 32'd55); end
    set_idle();
  endtask

  task automatic test_exc_select();
    logic [31:0] tIn[4], tId[4], tIf[4], tExp[4];
    logic        tFe[4], tFi[4];
    tIn = '{32'h00400008, 32'h80000100, 32'h00400008, 32'h80000100};
    tFe = '{1'b0, 1'b0, 1'b1, 1'b0};
    tId = '{32'h00400010, 32'h00400010, 32'h00400010, 32'h80000000};
    tFi = '{1'b0, 1'b0, 1'b1, 1'b0};
    tIf = '{32'h00400014, 32'h00400014, 32'h00400014, 32'h00400014};
    tExp = '{32'h00400008, 32'h00400010, 32'h00400014, 32'h00400014};
    set_idle();
    for (int i = 0; i < 4; i++) begin
      exc_req = 1; pc4_in = tIn[i]; flushed_ex = tFe[i]; pc4_id = tId[i]; flushed_id = tFi[i];
      pc4_if = tIf[i]; alu_in = 32'd100 + 32'(i); rd_in = 5'd7;
      push_exp(32'd100 + 32'(i), tExp[i], 5'd26, 1, 0, 2'd2);
      cycle();
    end
    set_idle();
    cycle();
    checks++; if (exc_pending !== 1'b0 || sb.size() != 0) begin
      errors++; $display("FAIL exc_sel_drain: got pending=%b queued=%0d, expected 0/0", exc_pending, sb.size()); end
  endtask

  task automatic test_pending_exc();
    set_idle();
    drive_valid(32'd10, 32'h00400100); push_exp(32'd10, 32'h00400100, 5'd3, 1, 0, 2'd1);
    cycle();
    out_ready = 0; drive_valid(32'd11, 32'h00400020); exc_req = 1;
    cycle();
    checks++; if (exc_pending !== 1'b1) begin errors++; $display("FAIL pend_set: got %b, expected 1", exc_pending); end
    pc4_in = 32'h00400060; flush = 1;
    cycle();
    checks++; if (exc_pending !== 1'b1 || alu_out !== 32'd10) begin
      errors++; $display("FAIL pend_hold: got pending=%b alu=%h, expected 1/%h", exc_pending, alu_out, 32'd10); end
    exc_req = 0; flush = 0; pc4_in = 32'h00400040; out_ready = 1;
    push_exp(32'd11, 32'h00400020, 5'd26, 1, 0, 2'd2);
    cycle();
    checks++; if (exc_pending !== 1'b0) begin errors++; $display("FAIL pend_clear: got %b, expected 0", exc_pending); end
    set_idle();
    cycle();
  endtask

  task automatic test_reset_mid_stall();
    set_idle();
    drive_valid(32'd20, 32'h00400200); push_exp(32'd20, 32'h00400200, 5'd3, 1, 0, 2'd1);
    cycle();
    out_ready = 0; in_valid = 0; exc_req = 1; pc4_in = 32'h00400030;
    cycle();
    set_idle();
    #2;
    reset = 0;
    #1;
    checks++; if (exc_pending !== 1'b0 || out_valid !== 1'b0) begin
      errors++; $display("FAIL rst_mid: got pending=%b valid=%b, expected 0/0", exc_pending, out_valid); end
    sb.delete();
    @(posedge clk);
    #1;
    reset = 1;
    cycle();
    checks++; if (out_valid !== 1'b0 || exc_pending !== 1'b0) begin
      errors++; $display("FAIL rst_mid_noinj: got valid=%b pending=%b, expected 0/0", out_valid, exc_pending); end
  endtask

  task automatic test_stats();
    logic [15:0] eStall, eBub, eExc;
`ifdef EXMEM_STATS_EN
    eStall = 16'd5; eBub = 16'd2; eExc = 16'd1;
`else
    eStall = 16'd0; eBub = 16'd0; eExc = 16'd0;
`endif
    apply_reset();
    drive_valid(32'd30, 32'h00400300); push_exp(32'd30, 32'h00400300, 5'd3, 1, 0, 2'd1);
    cycle();
    set_idle(); out_ready = 0;
    for (int i = 0; i < 5; i++) cycle();
    out_ready = 1; exc_req = 1; pc4_in = 32'h00400040;
    push_exp(32'd0, 32'h00400040, 5'd26, 1, 0, 2'd2);
    cycle();
    exc_req = 0;
    cycle();
    cycle();
    checks++; if (stall_cnt !== eStall) begin errors++; $display("FAIL stat_stall: got %0d, expected %0d", stall_cnt, eStall); end
    checks++; if (bubble_cnt !== eBub) begin errors++; $display("FAIL stat_bubble: got %0d, expected %0d", bubble_cnt, eBub); end
    checks++; if (exc_cnt !== eExc) begin errors++; $display("FAIL stat_exc: got %0d, expected %0d", exc_cnt, eExc); end
    checks++; if (sb.size() != 0) begin errors++; $display("FAIL stat_drain: got %0d queued, expected 0", sb.size()); end
  endtask

  initial begin
    test_reset();
    test_stream_backpressure();
    test_flush();
    test_exc_select();
    test_pending_exc();
    test_reset_mid_stall();
    test_stats();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
